// File: rtl/serial_cmd_responder_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial command responder:
//   state_t          - sequencer states (IDLE, ARM, WAIT_ACK, WAIT_DONE)
//   *_DEFAULT        - default header / reject / command-base byte values
//   nbytes()         - number of whole bytes needed to carry a sample
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT   = 8'h00;
  localparam logic [7:0] NAK_DEFAULT      = 8'h15;
  localparam logic [7:0] CMD_BASE_DEFAULT = 8'h78;

  // Bytes per sample, rounded up.
  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/serial_cmd_responder_if.sv
// -----------------------------------------------------------------------------
// serial_cmd_responder_if
// UART-side handshake bundle between the responder and the receiver /
// transmitter pair.
//   rx_valid  - one-cycle pulse, rx_data holds a received byte
//   rx_data   - received byte
//   tx_busy   - transmitter is shifting a byte out
//   tx_start  - one-cycle transmit request
//   tx_data   - byte to transmit
// Modports: master = responder side, slave = UART side.
// -----------------------------------------------------------------------------
interface serial_cmd_responder_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  rx_valid,
    input  rx_data,
    input  tx_busy,
    output tx_start,
    output tx_data
  );

  modport slave (
    output rx_valid,
    output rx_data,
    output tx_busy,
    input  tx_start,
    input  tx_data
  );
endinterface

// File: rtl/serial_cmd_responder_frame_builder.sv
// -----------------------------------------------------------------------------
// serial_frame_builder
// Channel mux, sample snapshot and response byte selection.
//   clk, rst_n   - clock, asynchronous active-low reset
//   sample_bus   - all channel samples, channel k at [k*DATA_W +: DATA_W]
//   load         - capture channel `ch` into the shadow register
//   ch           - channel to capture
//   nak          - current frame is a reject frame
//   idx          - frame byte index to present
//   byte_out     - frame byte at `idx`
// Optional: SERIAL_CMD_CHECKSUM_EN adds an XOR checksum byte after the payload.
// -----------------------------------------------------------------------------
module serial_frame_builder
  import serial_pkg::*;
#(
  parameter int         NUM_CH = 3,
  parameter int         DATA_W = 16,
  parameter logic [7:0] HEADER = HEADER_DEFAULT,
  parameter logic [7:0] NAK    = NAK_DEFAULT,
  parameter int         CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] sample_bus,
  input  logic                     load,
  input  logic [CH_W-1:0]          ch,
  input  logic                     nak,
  input  logic [2:0]               idx,
  output logic [7:0]               byte_out
);

  localparam int NB   = nbytes(DATA_W);
  localparam int SH_W = 8 * NB;

  logic [DATA_W-1:0] ch_word [NUM_CH];
  logic [DATA_W-1:0] sel_word;
  logic [SH_W-1:0]   shadow_reg;
  logic [7:0]        shadow_byte [NB];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_word[gi] = sample_bus[gi*DATA_W +: DATA_W];
    end
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      assign shadow_byte[gi] = shadow_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) sel_word = ch_word[i];
    end
  end

  // Snapshot decouples the frame in flight from later sample changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    shadow_reg <= '0;
    else if (load) shadow_reg <= SH_W'(sel_word);
  end

`ifdef SERIAL_CMD_CHECKSUM_EN
  logic [7:0] checksum;
  always_comb begin
    checksum = HEADER;
    for (int i = 0; i < NB; i++) checksum = checksum ^ shadow_byte[i];
  end
`endif

  // Frame layout: [0]=HEADER, [1..NB]=payload LSB first, [NB+1]=checksum.
  always_comb begin
    byte_out = HEADER;
    if (nak) begin
      byte_out = NAK;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (idx == 3'(i + 1)) byte_out = shadow_byte[i];
      end
`ifdef SERIAL_CMD_CHECKSUM_EN
      if (idx == 3'(NB + 1)) byte_out = checksum;
`endif
    end
  end

endmodule

// File: rtl/serial_cmd_responder.sv
// -----------------------------------------------------------------------------
// serial_cmd_responder
// Decodes command bytes into channel indices and streams a framed, LSB-first
// response through a UART transmitter with a start/busy handshake.
//   CLK_50      - system clock, rising edge
//   RST_N       - asynchronous active-low reset
//   uart        - rx_valid/rx_data/tx_busy in, tx_start/tx_data out
//   sample_bus  - NUM_CH samples of DATA_W bits
//   ch_sel      - last valid channel selected
//   busy        - frame in progress
//   drop_cnt    - commands discarded while busy, saturating at 255
// Optional: SERIAL_CMD_CHECKSUM_EN appends an XOR checksum to ACK frames.
// -----------------------------------------------------------------------------
module serial_cmd_responder
  import serial_pkg::*;
#(
  parameter int         NUM_CH   = 3,
  parameter int         DATA_W   = 16,
  parameter logic [7:0] CMD_BASE = CMD_BASE_DEFAULT,
  parameter logic [7:0] HEADER   = HEADER_DEFAULT,
  parameter logic [7:0] NAK      = NAK_DEFAULT,
  localparam int        CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK_50,
  input  logic                     RST_N,
  serial_cmd_responder_if.master   uart,
  input  logic [NUM_CH*DATA_W-1:0] sample_bus,
  output logic [CH_W-1:0]          ch_sel,
  output logic                     busy,
  output logic [7:0]               drop_cnt
);

  localparam int NB = nbytes(DATA_W);
`ifdef SERIAL_CMD_CHECKSUM_EN
  localparam int FRAME_LEN = NB + 2;
`else
  localparam int FRAME_LEN = NB + 1;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t           state_reg, state_next;
  logic [2:0]       idx_reg, idx_next;
  logic             nak_reg, nak_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic [CH_W-1:0]  ch_sel_reg, ch_sel_next;
  logic [7:0]       drop_cnt_reg, drop_cnt_next;
  logic             tx_start_c;
  logic             load;
  logic [7:0]       cmd_offset;
  logic             cmd_ok;
  logic [2:0]       next_idx;
  logic [7:0]       frame_byte;

  // Unsigned wrap makes bytes below CMD_BASE land far above NUM_CH.
  assign cmd_offset = uart.rx_data - CMD_BASE;
  assign cmd_ok     = (cmd_offset < 8'(NUM_CH));
  assign next_idx   = idx_reg + 3'd1;

  serial_frame_builder #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .HEADER (HEADER),
    .NAK    (NAK),
    .CH_W   (CH_W)
  ) u_builder (
    .clk        (CLK_50),
    .rst_n      (RST_N),
    .sample_bus (sample_bus),
    .load       (load),
    .ch         (cmd_offset[CH_W-1:0]),
    .nak        (nak_reg),
    .idx        (next_idx),
    .byte_out   (frame_byte)
  );

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      nak_reg      <= 1'b0;
      tx_data_reg  <= 8'h00;
      ch_sel_reg   <= '0;
      drop_cnt_reg <= 8'h00;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      nak_reg      <= nak_next;
      tx_data_reg  <= tx_data_next;
      ch_sel_reg   <= ch_sel_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    nak_next      = nak_reg;
    tx_data_next  = tx_data_reg;
    ch_sel_next   = ch_sel_reg;
    drop_cnt_next = drop_cnt_reg;
    tx_start_c    = 1'b0;
    load          = 1'b0;

    if (uart.rx_valid && (state_reg != IDLE) && (drop_cnt_reg != 8'hFF))
      drop_cnt_next = drop_cnt_reg + 8'd1;

    case (state_reg)
      IDLE: begin
        if (uart.rx_valid) begin
          idx_next   = '0;
          state_next = ARM;
          // The first byte never depends on the shadow, so it can be loaded
          // in the same edge that captures the snapshot.
          if (cmd_ok) begin
            nak_next     = 1'b0;
            ch_sel_next  = cmd_offset[CH_W-1:0];
            load         = 1'b1;
            tx_data_next = HEADER;
          end else begin
            nak_next     = 1'b1;
            tx_data_next = NAK;
          end
        end
      end
      ARM: begin
        if (!uart.tx_busy) begin
          tx_start_c = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (uart.tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!uart.tx_busy) begin
          if (idx_reg != (nak_reg ? 3'd0 : LAST_IDX)) begin
            idx_next     = next_idx;
            tx_data_next = frame_byte;
            state_next   = ARM;
          end else begin
            idx_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign uart.tx_start = tx_start_c;
  assign uart.tx_data  = tx_data_reg;
  assign ch_sel        = ch_sel_reg;
  assign busy          = (state_reg != IDLE);
  assign drop_cnt      = drop_cnt_reg;

endmodule
